// File: rtl/cdc_handshake_tx_pkg.sv
// Shared definitions for the 4-phase req/ack crossing. The receiver side reuses
// the state encoding and the minimum synchronizer depth from here.
package cdc_handshake_tx_pkg;

    // Handshake phase encoding; 2'd3 is unused and recovers to idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } hs_state_t;

    // Fewest flops that can be trusted to resolve metastability.
    localparam int unsigned MIN_SYNC_DEPTH = 2;

    // Local cycles for one transfer when the far side answers instantly.
    function automatic int unsigned min_xfer_cycles(input int unsigned sync_depth);
        return 2 * (sync_depth + 1);
    endfunction

endpackage

// File: rtl/cdc_ack_sync.sv
// Multi-flop synchronizer for the far-domain acknowledge.
// Kept as its own module so timing constraints can target its instance.
//
// Ports:
//   iw_clk    local clock
//   iw_rst_n  asynchronous active-low reset; all stages clear to 0
//   iw_async  signal from the far clock domain
//   ow_sync   iw_async delayed by p_SYNC_DEPTH local flops
module cdc_ack_sync
    import cdc_handshake_tx_pkg::*;
#(
    parameter int unsigned p_SYNC_DEPTH = 2
) (
    input  logic iw_clk,
    input  logic iw_rst_n,
    input  logic iw_async,
    output logic ow_sync
);

    // Depths below the safe minimum are raised to it.
    localparam int unsigned DEPTH = (p_SYNC_DEPTH < MIN_SYNC_DEPTH) ? MIN_SYNC_DEPTH
                                                                     : p_SYNC_DEPTH;

    logic [DEPTH-1:0] sync_q;

    // Shift chain; stage 0 is the only flop that may go metastable.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], iw_async};
        end
    end

    assign ow_sync = sync_q[DEPTH-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack clock-domain crossing. Captures a word on
// accept, holds it on a registered bus, raises a registered request, and waits
// for the synchronized acknowledge to rise and fall before taking another word.
//
// Ports:
//   iw_clk        local clock
//   iw_rst_n      asynchronous active-low reset
//   iwv_data      word to transfer, sampled on accept
//   iw_valid      source offers iwv_data
//   ow_ready      block can accept (from state and synchronized ack only)
//   owv_data      registered data toward the far domain
//   ow_req        registered request toward the far domain
//   iw_ack        asynchronous acknowledge from the far domain
//   ow_done       one-cycle pulse when a transfer completes
//   ow_proto_err  one-cycle pulse on an acknowledge protocol violation
module cdc_handshake_tx
    import cdc_handshake_tx_pkg::*;
#(
    parameter int unsigned          p_WIDTH      = 8,
    parameter int unsigned          p_SYNC_DEPTH = 2,
    parameter logic [p_WIDTH-1:0]   p_INIT_VALUE = '0
) (
    input  logic               iw_clk,
    input  logic               iw_rst_n,
    input  logic [p_WIDTH-1:0] iwv_data,
    input  logic               iw_valid,
    output logic               ow_ready,
    output logic [p_WIDTH-1:0] owv_data,
    output logic               ow_req,
    input  logic               iw_ack,
    output logic               ow_done,
    output logic               ow_proto_err
);

    hs_state_t state;
    logic      ack_s;
    logic      ack_q;
    logic      ack_rise;
    logic      ack_fall;
    logic      accept;

    // The raw acknowledge is used nowhere except as this synchronizer's input.
    cdc_ack_sync #(
        .p_SYNC_DEPTH (p_SYNC_DEPTH)
    ) u_ack_sync (
        .iw_clk   (iw_clk),
        .iw_rst_n (iw_rst_n),
        .iw_async (iw_ack),
        .ow_sync  (ack_s)
    );

    // Edge detection on the synchronized ack, used only for error reporting.
    assign ack_rise = ack_s & ~ack_q;
    assign ack_fall = ~ack_s & ack_q;

    // A lingering ack in idle blocks new work until the far side lets go.
    assign ow_ready = (state == ST_IDLE) && !ack_s;
    assign accept   = iw_valid && ow_ready;

    // Handshake sequencer with registered req, data and status pulses.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state        <= ST_IDLE;
            ow_req       <= 1'b0;
            owv_data     <= p_INIT_VALUE;
            ow_done      <= 1'b0;
            ow_proto_err <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            ow_done      <= 1'b0;
            ow_proto_err <= 1'b0;
            ack_q        <= ack_s;

            case (state)
                ST_IDLE: begin
                    // An ack rising with no request outstanding is a far-side fault.
                    if (ack_rise) begin
                        ow_proto_err <= 1'b1;
                    end else if (accept) begin
                        owv_data <= iwv_data;
                        ow_req   <= 1'b1;
                        state    <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (ack_s) begin
                        ow_req <= 1'b0;
                        state  <= ST_REL;
                    end else if (ack_fall) begin
                        // Ack dropped before it was ever seen high here.
                        ow_proto_err <= 1'b1;
                    end
                end

                ST_REL: begin
                    if (!ack_s) begin
                        ow_done <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end

                default: begin
                    ow_req <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench for cdc_handshake_tx with a behavioural far-side consumer.
`timescale 1ns/1ps
module tb_cdc_handshake_tx;

    localparam int unsigned W    = 8;
    localparam int unsigned D    = 2;
    localparam logic [W-1:0] INIT = 8'h00;

    logic         iw_clk   = 1'b0;
    logic         iw_rst_n = 1'b0;
    logic [W-1:0] iwv_data = '0;
    logic         iw_valid = 1'b0;
    logic         iw_ack   = 1'b0;
    logic         ow_ready;
    logic [W-1:0] owv_data;
    logic         ow_req;
    logic         ow_done;
    logic         ow_proto_err;

    cdc_handshake_tx #(
        .p_WIDTH      (W),
        .p_SYNC_DEPTH (D),
        .p_INIT_VALUE (INIT)
    ) dut (
        .iw_clk       (iw_clk),
        .iw_rst_n     (iw_rst_n),
        .iwv_data     (iwv_data),
        .iw_valid     (iw_valid),
        .ow_ready     (ow_ready),
        .owv_data     (owv_data),
        .ow_req       (ow_req),
        .iw_ack       (iw_ack),
        .ow_done      (ow_done),
        .ow_proto_err (ow_proto_err)
    );

    always #5 iw_clk = ~iw_clk;

    int unsigned cyc = 0;
    always @(posedge iw_clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] w;
        int unsigned  at;
    } acc_t;

    acc_t        exp_q[$];
    int unsigned fall_q[$];
    int unsigned done_q[$];
    acc_t        cur;

    int unsigned n_checks = 0, n_pass = 0;
    int unsigned n_accept = 0, n_done = 0, n_abandon = 0, err_cnt = 0;
    bit          err_window = 0, far_en = 1, far_rand = 0, spur_ack = 0;
    int unsigned far_rise_dly = 5, far_fall_dly = 5;
    int unsigned f_phase = 0, f_cnt = 0;
    logic [W-1:0] last_word = INIT;
    bit          prev_req = 0, rel_phase = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic int unsigned pick(input int unsigned fixed);
        return far_rand ? $urandom_range(1, 6) : fixed;
    endfunction

    // Far-side consumer: acks some cycles after req rises, releases some cycles
    // after req falls, and predicts when the local side must react.
    initial begin
        forever begin
            @(posedge iw_clk); #1;
            if (!iw_rst_n) begin
                f_phase = 0;
                iw_ack  = 1'b0;
            end else if (!far_en) begin
                iw_ack = spur_ack;
            end else begin
                case (f_phase)
                    0: if (ow_req) begin f_cnt = pick(far_rise_dly); f_phase = 1; end
                    1: begin
                        f_cnt--;
                        if (f_cnt == 0) begin
                            iw_ack = 1'b1;
                            fall_q.push_back(cyc + D + 1);
                            f_phase = 2;
                        end
                    end
                    2: if (!ow_req) begin f_cnt = pick(far_fall_dly); f_phase = 3; end
                    default: begin
                        f_cnt--;
                        if (f_cnt == 0) begin
                            iw_ack = 1'b0;
                            done_q.push_back(cyc + D + 1);
                            f_phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: compares DUT outputs with scoreboard entries, then records accepts.
    always @(negedge iw_clk) begin
        if (!iw_rst_n) begin
            chk("rst_req", 32'(ow_req), 0);
            chk("rst_data", 32'(owv_data), 32'(INIT));
            chk("rst_done", 32'(ow_done), 0);
            chk("rst_err", 32'(ow_proto_err), 0);
            prev_req  = 0;
            rel_phase = 0;
            last_word = INIT;
        end else begin
            if (ow_req && !prev_req) begin
                if (exp_q.size() == 0) fail_now("unexpected_req");
                else begin
                    cur = exp_q.pop_front();
                    chk("req_data", 32'(owv_data), 32'(cur.w));
                    chk("req_latency", cyc, cur.at);
                    last_word = cur.w;
                end
            end
            if (!ow_req && prev_req) begin
                if (fall_q.size() == 0) fail_now("unexpected_req_fall");
                else chk("req_fall_cycle", cyc, fall_q.pop_front());
                rel_phase = 1;
            end
            if (ow_done) begin
                if (done_q.size() == 0) fail_now("unexpected_done");
                else chk("done_cycle", cyc, done_q.pop_front());
                n_done++;
                rel_phase = 0;
            end
            chk("data_stable", 32'(owv_data), 32'(last_word));
            if (ow_req || rel_phase) chk("ready_low_busy", 32'(ow_ready), 0);
            if (!err_window) chk("no_proto_err", 32'(ow_proto_err), 0);
            else if (ow_proto_err) err_cnt++;
            prev_req = ow_req;
            if (iw_valid && ow_ready) begin
                exp_q.push_back('{w: iwv_data, at: cyc + 1});
                n_accept++;
            end
        end
    end

    // Offer a word until it is accepted; returns 1ns after the accepting edge.
    task automatic send(input logic [W-1:0] w, input bit hold);
        int unsigned t = 0;
        iwv_data = w;
        iw_valid = 1'b1;
        forever begin
            @(negedge iw_clk);
            if (ow_ready) break;
            t++;
            if (t > 200) begin fail_now("accept_timeout"); break; end
        end
        @(posedge iw_clk); #1;
        if (!hold) iw_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned t = 0;
        forever begin
            @(negedge iw_clk);
            if (n_done + n_abandon == n_accept && exp_q.size() == 0 && !ow_req && !rel_phase) break;
            t++;
            if (t > 400) begin fail_now("idle_timeout"); break; end
        end
        @(posedge iw_clk); #1;
    endtask

    int unsigned a0, d0, e0, t0;

    initial begin
        // Reset and idle
        repeat (3) @(posedge iw_clk);
        #1 iw_rst_n = 1'b1;
        @(negedge iw_clk);
        chk("idle_ready", 32'(ow_ready), 1);
        chk("idle_req", 32'(ow_req), 0);
        chk("idle_data", 32'(owv_data), 32'(INIT));
        @(posedge iw_clk); #1;

        // Single transfer with fixed 5-cycle far latencies
        a0 = n_accept; d0 = n_done;
        send(8'hA5, 0);
        wait_idle();
        chk("single_accepts", n_accept - a0, 1);
        chk("single_dones", n_done - d0, 1);

        // Back-to-back with valid held high
        a0 = n_accept; d0 = n_done;
        far_rise_dly = 2; far_fall_dly = 1;
        send(8'h01, 1);
        send(8'h02, 1);
        send(8'h03, 0);
        wait_idle();
        chk("b2b_accepts", n_accept - a0, 3);
        chk("b2b_dones", n_done - d0, 3);

        // Offer during REQ must be ignored
        far_rise_dly = 5; far_fall_dly = 5;
        a0 = n_accept;
        send(8'h5A, 0);
        @(posedge iw_clk); #1;
        iwv_data = 8'hFF; iw_valid = 1'b1;
        @(negedge iw_clk);
        chk("offer_in_req", 32'(ow_req), 1);
        @(posedge iw_clk); #1;
        iw_valid = 1'b0;
        wait_idle();
        chk("ignored_accepts", n_accept - a0, 1);
        chk("ignored_data", 32'(owv_data), 32'h5A);

        // Spurious ack in idle for 4 cycles
        @(negedge iw_clk);
        far_en = 0; err_window = 1; e0 = err_cnt;
        spur_ack = 1; t0 = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge iw_clk);
            if (cyc == t0 + 3) spur_ack = 0;
            chk("spur_ready", 32'(ow_ready),
                32'((cyc >= t0 + D && cyc < t0 + 4 + D) ? 0 : 1));
        end
        chk("spur_err_pulses", err_cnt - e0, 1);
        err_window = 0;
        far_en = 1;
        @(posedge iw_clk); #1;

        // Reset mid-transfer, then a clean transfer
        send(8'h77, 0);
        @(posedge iw_clk); #2;
        iw_rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(ow_req), 0);
        chk("async_rst_data", 32'(owv_data), 32'(INIT));
        n_abandon++;
        fall_q.delete();
        done_q.delete();
        repeat (2) @(posedge iw_clk);
        #1 iw_rst_n = 1'b1;
        a0 = n_accept; d0 = n_done;
        send(8'h3C, 0);
        wait_idle();
        chk("post_rst_dones", n_done - d0, 1);
        chk("post_rst_data", 32'(owv_data), 32'h3C);

        // Randomized traffic with random far-side latencies
        far_rand = 1;
        for (int i = 0; i < 30; i++) begin
            int unsigned gap = $urandom_range(0, 3);
            if (gap != 0) begin
                iw_valid = 1'b0;
                repeat (gap) begin @(posedge iw_clk); #1; end
            end
            send(W'($urandom), bit'($urandom_range(0, 1)));
        end
        iw_valid = 1'b0;
        wait_idle();

        chk("queues_empty", exp_q.size() + fall_q.size() + done_q.size(), 0);
        chk("done_total", n_done, n_accept - n_abandon);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
Source-side half of a 4-phase req/ack clock-domain crossing. It accepts a data word in the local clock domain, holds it stable on a registered bus, and raises a registered request toward an asynchronous consumer. It synchronizes the consumer's acknowledge internally and completes the full four-phase cycle before accepting the next word. It pairs with the input synchronizer chain on the consumer side, and is the block driving signals that such a chain samples.

Parameters:
p_WIDTH, 8, data bus width in bits.
p_SYNC_DEPTH, 2, flip-flop stages on the incoming ack; legal range is 2 or more.
p_INIT_VALUE, 0, reset value of owv_data.

Ports:
iw_clk  input  1  local clock.
iw_rst_n  input  1  asynchronous active-low reset.
iwv_data  input  p_WIDTH  word to transfer; sampled on accept.
iw_valid  input  1  source offers iwv_data.
ow_ready  output  1  block can accept; an accept occurs on an edge where iw_valid and ow_ready are both high.
owv_data  output  p_WIDTH  registered data to the far domain; stable while ow_req is high and until ack drops.
ow_req  output  1  registered request to the far domain; glitch-free, driven directly from a flop.
iw_ack  input  1  asynchronous acknowledge from the far domain.
ow_done  output  1  one-cycle pulse when a transfer fully completes.
ow_proto_err  output  1  one-cycle pulse on an ack protocol violation.

Behaviour:
- Reset (asynchronous, while iw_rst_n is 0):
  - state = IDLE, ow_req = 0, owv_data = p_INIT_VALUE, ow_done = 0, ow_proto_err = 0.
  - All ack synchronizer stages = 0.
- Synchronization: the internal signal ack_s is iw_ack delayed by p_SYNC_DEPTH flops. No logic uses iw_ack directly.
- State machine (all registered):
  - IDLE: ow_ready = (ack_s == 0). On accept: owv_data <= iwv_data, ow_req <= 1, go to REQ.
  - REQ: ow_req = 1, ow_ready = 0. When ack_s = 1: ow_req <= 0, go to REL.
  - REL: ow_req = 0, ow_ready = 0. When ack_s = 0: ow_done <= 1 for one cycle, go to IDLE.
- Latency:
  - Accept at edge N gives ow_req = 1 after edge N.
  - A far-side ack rise reaches ack_s after p_SYNC_DEPTH local edges; ow_req falls on the following edge.
  - Minimum local cycles per transfer is 2*(p_SYNC_DEPTH+1) plus the far-side latency.
- Data stability: owv_data changes only on accept. It is never updated in REQ or REL.
- ow_ready is combinational from state and ack_s only, never from iw_valid.
- iw_valid while not ready: the offer is ignored. No capture, no error.
- Protocol errors (ow_proto_err pulses one cycle, state unaffected):
  - ack_s rises while in IDLE. ow_ready stays low until ack_s returns to 0.
  - ack_s falls while in REQ before it was seen high. State stays REQ.
- Simultaneous events: ow_done and an accept cannot coincide, because ow_ready is low in REL. The next accept can occur on the edge after the REL-to-IDLE transition.
- Reset mid-transfer: ow_req drops asynchronously and the transfer is abandoned. No ow_done is issued. The far side must tolerate req falling before ack; this is a system-level contract.
- Back-to-back use: a valid held high continuously gives one accept per completed 4-phase cycle, with no lost or duplicated words.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, REQ=2'd1, REL=2'd2) and the minimum sync depth constant (2). The receiver side reuses these.
- One sub-module: cdc_ack_sync.
  - A p_SYNC_DEPTH-stage 1-bit synchronizer with asynchronous active-low reset to 0.
  - Instantiated once for iw_ack.
  - Kept separate so synthesis and timing constraints can target it.

Test Plan:
- Reset and idle: hold iw_rst_n=0 for 3 cycles, then release with iw_ack=0 -> ow_req=0, owv_data=0, ow_ready=1, no pulses.
- Single transfer (p_SYNC_DEPTH=2): accept 8'hA5 at edge N; the model acks 5 cycles after req rises and drops ack 5 cycles after req falls.
  - ow_req is high from N+1.
  - owv_data is 8'hA5 throughout.
  - ow_req falls 3 edges after ack rises.
  - ow_done pulses once, 3 edges after ack falls.
- Back-to-back: hold iw_valid=1 with words 8'h01, 8'h02, 8'h03 presented in turn.
  - Exactly three accepts and three ow_done pulses.
  - owv_data sequence is 01, 02, 03.
  - ow_ready is never high in REQ or REL.
- Ignored offer: pulse iw_valid with 8'hFF during REQ -> owv_data is unchanged and no extra transfer occurs.
- Spurious ack: drive iw_ack=1 in IDLE for 4 cycles.
  - ow_proto_err pulses once.
  - ow_ready stays 0 until ack_s drops, then returns to 1.
- Reset mid-transfer: assert iw_rst_n=0 while in REQ.
  - ow_req and owv_data clear immediately, without waiting for a clock.
  - No ow_done.
  - After release, the next transfer of 8'h3C completes normally.
